input_deframer: RTL and testbench

INPUT_DEFRAMER -- requirements
Module: input_deframer

---
 rtl/input_deframer.sv | 201 ++++++++++++++++++++
 tb/tb_input_deframer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_deframer.sv
// Splits a flag-framed compressed byte stream into literal and copy items.
// A header of FRAME_SIZE flag bits precedes each frame; one output register holds the current item.
module input_deframer #(
  parameter int FRAME_SIZE = 8
) (
  input  logic        ClkxCI,
  input  logic        RstxRI,
  input  logic [7:0]  InDataxDI,
  input  logic        InValidxSI,
  input  logic        InLastxSI,
  output logic        InReadyxSO,
  output logic        ItemValidxSO,
  input  logic        ItemReadyxSI,
  output logic        ItemIsCopyxSO,
  output logic [7:0]  LiteralxDO,
  output logic [11:0] OffsetxDO,
  output logic [4:0]  LengthxDO,
  output logic        FrameDonexSO,
  output logic        DonexSO,
  output logic        ErrorxSO
);

  localparam int HDR_BYTES = FRAME_SIZE / 8;

  localparam logic [1:0] HDR     = 2'd0;
  localparam logic [1:0] ITEM    = 2'd1;
  localparam logic [1:0] COPY_LO = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [FRAME_SIZE-1:0] hdr_q, hdr_d;
  logic                  hdrCnt_q, hdrCnt_d;
  logic [3:0]            itemIdx_q, itemIdx_d;
  logic [7:0]            b0_q, b0_d;
  logic                  itemValid_q, itemValid_d;
  logic                  isCopy_q, isCopy_d;
  logic [7:0]            literal_q, literal_d;
  logic [11:0]           offset_q, offset_d;
  logic [4:0]            length_q, length_d;
  logic                  frameDone_q, frameDone_d;
  logic                  error_q, error_d;

  logic                  inReady;
  logic                  accept;
  logic                  take;
  logic                  itemLoad;
  logic                  lastHdrByte;
  logic                  lastItem;
  logic                  curFlag;
  logic [FRAME_SIZE-1:0] hdrShift;
  logic [11:0]           copyOffset;

  // The single output register lets a new byte in whenever the slot is empty or being drained.
  always_comb begin
    case (state_q)
      HDR:          inReady = 1'b1;
      ITEM,
      COPY_LO:      inReady = ~itemValid_q | ItemReadyxSI;
      default:      inReady = 1'b0;
    endcase
  end

  assign accept      = InValidxSI & inReady;
  assign take        = itemValid_q & ItemReadyxSI;
  assign lastHdrByte = (HDR_BYTES == 1) || hdrCnt_q;
  assign lastItem    = (itemIdx_q == 4'(FRAME_SIZE - 1));
  assign hdrShift    = hdr_q >> itemIdx_q;
  assign curFlag     = hdrShift[0];
  assign copyOffset  = {b0_q[7:4], InDataxDI};

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdrCnt_d    = hdrCnt_q;
    itemIdx_d   = itemIdx_q;
    b0_d        = b0_q;
    itemValid_d = itemValid_q;
    isCopy_d    = isCopy_q;
    literal_d   = literal_q;
    offset_d    = offset_q;
    length_d    = length_q;
    frameDone_d = frameDone_q;
    error_d     = error_q;
    itemLoad    = 1'b0;

    if (take) begin
      itemValid_d = 1'b0;
      frameDone_d = 1'b0;
    end

    case (state_q)
      HDR: begin
        if (accept) begin
          if (hdrCnt_q == 1'b0) begin
            hdr_d[7:0] = InDataxDI;
          end else begin
            hdr_d[FRAME_SIZE-1 -: 8] = InDataxDI;
          end
          if (lastHdrByte) begin
            hdrCnt_d  = 1'b0;
            itemIdx_d = 4'd0;
            state_d   = ITEM;
          end else begin
            hdrCnt_d = 1'b1;
          end
          // A stream may legally end partway through a header.
          if (InLastxSI) begin
            state_d = DONE;
          end
        end
      end
      ITEM: begin
        if (accept) begin
          if (!curFlag) begin
            itemLoad  = 1'b1;
            isCopy_d  = 1'b0;
            literal_d = InDataxDI;
            offset_d  = 12'd0;
            length_d  = 5'd0;
          end else if (InLastxSI) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            b0_d    = InDataxDI;
            state_d = COPY_LO;
          end
        end
      end
      COPY_LO: begin
        if (accept) begin
          itemLoad  = 1'b1;
          isCopy_d  = 1'b1;
          literal_d = 8'd0;
          offset_d  = copyOffset;
          length_d  = 5'(b0_q[3:0]) + 5'd3;
          if (copyOffset == 12'd0) begin
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Common bookkeeping for any item that completes this cycle.
    if (itemLoad) begin
      itemValid_d = 1'b1;
      frameDone_d = lastItem;
      if (lastItem) begin
        itemIdx_d = 4'd0;
        state_d   = HDR;
      end else begin
        itemIdx_d = itemIdx_q + 4'd1;
        state_d   = ITEM;
      end
      if (InLastxSI) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q     <= HDR;
      hdr_q       <= '0;
      hdrCnt_q    <= 1'b0;
      itemIdx_q   <= 4'd0;
      b0_q        <= 8'd0;
      itemValid_q <= 1'b0;
      isCopy_q    <= 1'b0;
      literal_q   <= 8'd0;
      offset_q    <= 12'd0;
      length_q    <= 5'd0;
      frameDone_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdrCnt_q    <= hdrCnt_d;
      itemIdx_q   <= itemIdx_d;
      b0_q        <= b0_d;
      itemValid_q <= itemValid_d;
      isCopy_q    <= isCopy_d;
      literal_q   <= literal_d;
      offset_q    <= offset_d;
      length_q    <= length_d;
      frameDone_q <= frameDone_d;
      error_q     <= error_d;
    end
  end

  assign InReadyxSO    = inReady;
  assign ItemValidxSO  = itemValid_q;
  assign ItemIsCopyxSO = isCopy_q;
  assign LiteralxDO    = literal_q;
  assign OffsetxDO     = offset_q;
  assign LengthxDO     = length_q;
  assign FrameDonexSO  = frameDone_q;
  assign DonexSO       = (state_q == DONE) & ~itemValid_q;
  assign ErrorxSO      = error_q;

endmodule

// File: tb/tb_input_deframer.sv
// Randomized bench for input_deframer: two instances (FRAME_SIZE 8 and 16) share stimulus,
// and the selected one is scored against a byte-stream parsing model.
module tb_input_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       = 1'b0;
  logic [7:0] inData    = 8'd0;
  logic       inValid   = 1'b0;
  logic       inLast    = 1'b0;
  logic       itemReady = 1'b0;

  logic        inReady8, itemValid8, isCopy8, frameDone8, done8, error8;
  logic [7:0]  lit8;
  logic [11:0] off8;
  logic [4:0]  len8;
  logic        inReady16, itemValid16, isCopy16, frameDone16, done16, error16;
  logic [7:0]  lit16;
  logic [11:0] off16;
  logic [4:0]  len16;

  input_deframer #(.FRAME_SIZE(8)) dut8 (
    .ClkxCI(clk), .RstxRI(rst), .InDataxDI(inData), .InValidxSI(inValid),
    .InLastxSI(inLast), .InReadyxSO(inReady8), .ItemValidxSO(itemValid8),
    .ItemReadyxSI(itemReady), .ItemIsCopyxSO(isCopy8), .LiteralxDO(lit8),
    .OffsetxDO(off8), .LengthxDO(len8), .FrameDonexSO(frameDone8),
    .DonexSO(done8), .ErrorxSO(error8)
  );

  input_deframer #(.FRAME_SIZE(16)) dut16 (
    .ClkxCI(clk), .RstxRI(rst), .InDataxDI(inData), .InValidxSI(inValid),
    .InLastxSI(inLast), .InReadyxSO(inReady16), .ItemValidxSO(itemValid16),
    .ItemReadyxSI(itemReady), .ItemIsCopyxSO(isCopy16), .LiteralxDO(lit16),
    .OffsetxDO(off16), .LengthxDO(len16), .FrameDonexSO(frameDone16),
    .DonexSO(done16), .ErrorxSO(error16)
  );

  int sel = 0;
  logic        oInReady, oItemValid, oIsCopy, oFrameDone, oDone, oError;
  logic [7:0]  oLit;
  logic [11:0] oOff;
  logic [4:0]  oLen;

  always_comb begin
    if (sel == 0) begin
      oInReady = inReady8;  oItemValid = itemValid8;  oIsCopy = isCopy8;
      oFrameDone = frameDone8; oDone = done8; oError = error8;
      oLit = lit8; oOff = off8; oLen = len8;
    end else begin
      oInReady = inReady16; oItemValid = itemValid16; oIsCopy = isCopy16;
      oFrameDone = frameDone16; oDone = done16; oError = error16;
      oLit = lit16; oOff = off16; oLen = len16;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  streamQ[$];
  logic [31:0] expItems[$];
  bit          isHdr[$];
  bit          completes[$];
  bit          expErr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkItem(input bit c, input bit fd, input logic [11:0] off,
                                         input logic [4:0] len, input logic [7:0] lit);
    if (c) return {5'd0, 1'b1, fd, off, len, 8'd0};
    return {5'd0, 1'b0, fd, 12'd0, 5'd0, lit};
  endfunction

  function automatic logic [31:0] obsItem();
    return mkItem(oIsCopy, oFrameDone, oOff, oLen, oLit);
  endfunction

  // Parse the byte stream directly: header bytes give flags, then literals or byte pairs.
  task automatic buildModel(input int fs);
    int n;
    int p;
    logic [15:0] flags;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] off;
    n = streamQ.size();
    p = 0;
    expItems.delete(); isHdr.delete(); completes.delete(); expErr = 0;
    for (int i = 0; i < n; i++) begin
      isHdr.push_back(1'b0);
      completes.push_back(1'b0);
    end
    while (p < n) begin
      flags = 16'd0;
      for (int h = 0; h < fs / 8 && p < n; h++) begin
        flags = flags | (16'(streamQ[p]) << (8 * h));
        isHdr[p] = 1'b1;
        p++;
      end
      for (int k = 0; k < fs && p < n; k++) begin
        if (!flags[k]) begin
          expItems.push_back(mkItem(1'b0, k == fs - 1, 12'd0, 5'd0, streamQ[p]));
          completes[p] = 1'b1;
          p++;
        end else if (p == n - 1) begin
          expErr = 1'b1;
          p++;
        end else begin
          b0  = streamQ[p];
          b1  = streamQ[p + 1];
          off = 12'(int'(b0 / 16) * 256 + int'(b1));
          if (off == 12'd0) expErr = 1'b1;
          expItems.push_back(mkItem(1'b1, k == fs - 1, off, 5'(int'(b0 % 16) + 3), 8'd0));
          completes[p + 1] = 1'b1;
          p += 2;
        end
      end
    end
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1; inValid = 1'b0; inLast = 1'b0; itemReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetFlags", {26'd0, oInReady, oItemValid, oIsCopy, oFrameDone, oDone, oError},
                32'h20);
    checkOutput("resetData", {7'd0, oLit, oOff, oLen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pb(input logic [7:0] b);
    streamQ.push_back(b);
  endtask

  // Feed streamQ with random gaps and consumer stalls, scoring each taken item.
  task automatic applyStimulus(input int validPct, input int readyPct);
    int n;
    int p;
    int cycles;
    bit prevHold;
    bit expectItem;
    logic [31:0] held;
    n = streamQ.size();
    p = 0; cycles = 0; prevHold = 0; expectItem = 0; held = '0;
    while (cycles < 3000) begin
      if (p < n && int'($urandom_range(0, 99)) < validPct) begin
        inValid = 1'b1; inData = streamQ[p]; inLast = (p == n - 1);
      end else begin
        inValid = 1'b0; inData = 8'($urandom); inLast = 1'($urandom_range(0, 1));
      end
      itemReady = (int'($urandom_range(0, 99)) < readyPct);
      @(negedge clk);
      if (expectItem) checkOutput("latency", {31'd0, oItemValid}, 32'd1);
      expectItem = 0;
      if (prevHold) checkOutput("hold", obsItem(), held);
      prevHold = oItemValid & ~itemReady;
      held = obsItem();
      if (p < n) begin
        checkOutput("earlyDone", {31'd0, oDone}, 32'd0);
        if (isHdr[p]) checkOutput("hdrReady", {31'd0, oInReady}, 32'd1);
        else if (oItemValid && !itemReady) checkOutput("stallReady", {31'd0, oInReady}, 32'd0);
        else checkOutput("itemReady", {31'd0, oInReady}, 32'd1);
      end
      if (oItemValid && itemReady) begin
        if (expItems.size() > 0) checkOutput("item", obsItem(), expItems.pop_front());
        else checkOutput("spurious", {31'd0, oItemValid}, 32'd0);
      end
      if (inValid && oInReady) begin
        if (completes[p]) expectItem = 1;
        p++;
      end
      if (p == n && oDone) break;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("doneReached", {31'd0, oDone}, 32'd1);
    checkOutput("error", {31'd0, oError}, {31'd0, expErr});
    checkOutput("leftover", expItems.size(), 32'd0);
    @(posedge clk); #1;
    inValid = 1'b1; inLast = 1'b0; itemReady = 1'b1;
    @(negedge clk);
    checkOutput("doneHold", {30'd0, oInReady, oDone}, 32'd1);
    inValid = 1'b0;
  endtask

  task automatic runCase(input int s, input int validPct, input int readyPct);
    sel = s;
    buildModel(s == 0 ? 8 : 16);
    resetDut();
    applyStimulus(validPct, readyPct);
  endtask

  initial begin
    // Eight literals in one frame at full rate, then with consumer stalls.
    streamQ.delete(); pb(8'h00);
    for (int i = 0; i < 8; i++) pb(8'(8'h41 + i));
    runCase(0, 100, 100);
    runCase(0, 100, 40);

    // Copy first, seven literals, then a second header.
    streamQ.delete(); pb(8'h01); pb(8'h3A); pb(8'h05);
    for (int i = 0; i < 7; i++) pb(8'(8'h41 + i));
    pb(8'h00); pb(8'h50);
    runCase(0, 100, 100);

    // Stream ends on the third literal.
    streamQ.delete(); pb(8'h00); pb(8'h41); pb(8'h42); pb(8'h43);
    runCase(0, 100, 50);

    // Stream ends on a copy's first byte.
    streamQ.delete(); pb(8'h01); pb(8'h12);
    runCase(0, 100, 100);

    // Zero-offset copy.
    streamQ.delete(); pb(8'h01); pb(8'h00); pb(8'h00); pb(8'h41);
    runCase(0, 100, 100);

    // Reset while a copy's first byte is pending.
    sel = 0;
    resetDut();
    itemReady = 1'b1; inValid = 1'b1; inLast = 1'b0; inData = 8'h01;
    @(posedge clk); #1;
    inData = 8'h3A;
    @(posedge clk); #1;
    inValid = 1'b0;
    streamQ.delete(); pb(8'h00); pb(8'h7A);
    runCase(0, 100, 100);

    // Sixteen-item frame with copies at both ends, then an empty tail header byte.
    streamQ.delete(); pb(8'h01); pb(8'h80); pb(8'h21); pb(8'h34);
    for (int i = 0; i < 14; i++) pb(8'(8'h60 + i));
    pb(8'h9F); pb(8'hFF); pb(8'h55);
    runCase(1, 100, 100);

    for (int r = 0; r < 40; r++) begin
      streamQ.delete();
      for (int i = 0; i < int'($urandom_range(1, 50)); i++) pb(8'($urandom));
      runCase(r % 2, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
